// File: rtl/fifo_bwd.sv
// fifo_bwd: two-entry fully registered FIFO (skid buffer) that cuts both the
// forward data/valid path and the backward if_full_n path.
module fifo_bwd #(
    parameter              MEM_STYLE  = "",
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
);
    // State bits are {if_empty_n, if_full_n}, so both flags come straight off flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b01,
        ONE   = 2'b11,
        TWO   = 2'b10
    } state_t;

    // The compatibility parameters are accepted but have no effect on the hardware.
    if (DEPTH < 2 && ADDR_WIDTH < 1 && MEM_STYLE != "") begin : g_compat
    end

    state_t                state, next;
    logic [DATA_WIDTH-1:0] head, skid;
    logic                  wr, rd, load_head, load_skid, shift;

    assign if_empty_n = state[1];
    assign if_full_n  = state[0];
    assign if_dout    = head;
    assign wr = if_write && if_write_ce && if_full_n;
    assign rd = if_read && if_read_ce && if_empty_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= next;
            if (load_head) head <= if_din;
            else if (shift) head <= skid;
            if (load_skid) skid <= if_din;
        end
    end

    always_comb begin
        next      = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        case (state)
            EMPTY: begin
                next      = wr ? ONE : EMPTY;
                load_head = wr;
            end
            ONE: begin
                next      = (wr && !rd) ? TWO : (rd && !wr) ? EMPTY : ONE;
                load_head = wr && rd;
                load_skid = wr && !rd;
            end
            TWO: begin
                next  = rd ? ONE : TWO;
                shift = rd;
            end
            default: next = EMPTY;
        endcase
    end
endmodule
